shot_clock_display: RTL and testbench
=====================================

# shot_clock_display

Display and alarm back-end for the basketball shot clock on the DE10-Lite. It consumes the 5-bit countdown value and pause flag produced by the shot-clock divider/counter and drives two active-low seven-segment digits (HEX1 tens, HEX0 units). It also sounds a fixed-length buzzer when the count expires, then blinks "00" until the clock is reloaded.

## Interface
- `BUZZ_CYCLES`, default 50000000: buzzer duration in clk cycles (1 s at 50 MHz); legal range ≥1.
- `BLINK_HALF`, default 12500000: half-period of the expired-state blink in clk cycles; legal range ≥1.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `count_in` in 5: current countdown value, 0–31.
- `pause` in 1: countdown paused.
- `hex0` out 8: units digit, active-low, bit order {dp,g,f,e,d,c,b,a}.
- `hex1` out 8: tens digit, same encoding.
- `buzzer` out 1: horn drive, high while sounding.
- `expired` out 1: high in the BUZZ and EXPIRED states.

## Operation
- Digit conversion:
  - tens = 3 if count_in ≥30, 2 if ≥20, 1 if ≥10, else 0.
  - units = count_in − 10·tens.
  - All arithmetic is 5-bit unsigned; no value exceeds 31.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF.
- Leading-zero blanking: `hex1` = FF when tens = 0, except in EXPIRED-on phase, where it shows 0.
- Pause indicator: in IDLE with `pause`=1, the `hex0` dp bit is 0 (lit). The dp is otherwise 1.
- `prev_q` registers count_in every cycle. Expiry is detected when prev_q ≠ 0 and count_in = 0. Any nonzero-to-zero jump counts, including 5→0.
- FSM states:
  - IDLE: digits follow count_in. On expiry, go to BUZZ and clear the timer.
  - BUZZ: `buzzer`=1; digits show "00".
    - Timer reaches BUZZ_CYCLES−1: go to EXPIRED and clear the blink counter.
    - count_in ≠ 0 (clock reloaded): go to IDLE immediately. This takes priority over timer completion in the same cycle.
  - EXPIRED: `buzzer`=0.
    - Blink phase toggles every BLINK_HALF cycles, starting in the on phase.
    - On phase shows "00"; off phase shows FF/FF.
    - count_in ≠ 0: go to IDLE.
- `pause` does not stop the buzzer or the blink.
- count_in = 0 arriving straight out of reset does not trigger BUZZ, because prev_q resets to 0.

## Timing
- Reset values:
  - state = IDLE, prev_q = 0, timers = 0.
  - `hex0` = FF, `hex1` = FF, `buzzer` = 0, `expired` = 0.
- All outputs are registered.
- `hex0`/`hex1` reflect the count_in sampled at edge N starting from cycle N+1 (one-cycle latency).
- Buzzer timing: with expiry sampled at edge N, `buzzer` and `expired` rise in cycle N+1 and `buzzer` stays high for exactly BUZZ_CYCLES cycles.
- Blink timing: the first EXPIRED cycle shows "00". The display blanks after BLINK_HALF cycles.
- Reload during BUZZ or EXPIRED: `buzzer`/`expired` fall one cycle after the nonzero count_in is sampled, and the digits show the new value in that same cycle.
- Reset mid-BUZZ: all outputs return to their reset values in the cycle after rst is sampled.
- Timer widths: ceil(log2) of the respective parameter, minimum 1 bit.

## Structure
- Shared package `shot_clock_pkg`:
  - FSM state enum {IDLE, BUZZ, EXPIRED}.
  - SEG_BLANK constant (8'hFF).
  - Digit-to-segment lookup constants.
- Sub-module `seg7_decoder`: combinational 4-bit digit → 7-bit active-low segments. Instantiated twice; the dp bit is appended by the parent.

## Test plan
All scenarios use BUZZ_CYCLES=4 and BLINK_HALF=3.
- Reset, count_in=24, pause=0 → one cycle after reset release: hex1=A4, hex0=99, buzzer=0.
- count_in steps 10→9 → hex1=FF (blanked), hex0=90; count_in=31 → hex1=B0, hex0=F9.
- pause=1 with count_in=7 → hex0=78 (dp lit), hex1=FF.
- count_in 1→0 → buzzer high for exactly 4 cycles. Then expired=1, buzzer=0, and digits alternate C0/C0 for 3 cycles and FF/FF for 3 cycles, repeating.
- count_in 0→24 during the 2nd BUZZ cycle → buzzer/expired low next cycle, digits show 24, no EXPIRED entry.
- Reset with count_in held 0 → no buzzer. Assert rst mid-BUZZ → buzzer=0 and hex0/hex1=FF the next cycle.

Source files
------------

// File: rtl/shot_clock_pkg.sv
// Shared types and constants for the shot-clock display back-end:
// FSM state encoding, active-low segment codes and BCD digit split helpers.
package shot_clock_pkg;

  typedef enum logic [1:0] {IDLE, BUZZ, EXPIRED} state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  function automatic logic [1:0] tens_of(input logic [4:0] v);
    if (v >= 5'd30)      return 2'd3;
    else if (v >= 5'd20) return 2'd2;
    else if (v >= 5'd10) return 2'd1;
    else                 return 2'd0;
  endfunction

  // Count never exceeds 31, so the remainder always fits in 4 bits.
  function automatic logic [3:0] units_of(input logic [4:0] v);
    case (tens_of(v))
      2'd3:    return 4'(v - 5'd30);
      2'd2:    return 4'(v - 5'd20);
      2'd1:    return 4'(v - 5'd10);
      default: return 4'(v);
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit digit to 7-bit active-low segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 decode to blank.
module seg7_decoder
  import shot_clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK[6:0];
    case (digit)
      4'd0:    seg = SEG_0[6:0];
      4'd1:    seg = SEG_1[6:0];
      4'd2:    seg = SEG_2[6:0];
      4'd3:    seg = SEG_3[6:0];
      4'd4:    seg = SEG_4[6:0];
      4'd5:    seg = SEG_5[6:0];
      4'd6:    seg = SEG_6[6:0];
      4'd7:    seg = SEG_7[6:0];
      4'd8:    seg = SEG_8[6:0];
      4'd9:    seg = SEG_9[6:0];
      default: seg = SEG_BLANK[6:0];
    endcase
  end

endmodule

// File: rtl/shot_clock_display.sv
// Shot-clock display and alarm: two active-low 7-segment digits, a fixed-length
// buzzer on expiry, then a blinking "00" until the count is reloaded.
module shot_clock_display
  import shot_clock_pkg::*;
#(
  parameter int BUZZ_CYCLES = 50000000,
  parameter int BLINK_HALF  = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] count_in,
  input  logic       pause,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic       buzzer,
  output logic       expired
);

  localparam int BUZZ_W  = (BUZZ_CYCLES > 1) ? $clog2(BUZZ_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BUZZ_W-1:0]  BUZZ_LAST  = BUZZ_W'(BUZZ_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  state_t               state, state_d;
  logic [4:0]           prev_q;
  logic [BUZZ_W-1:0]    timer, timer_d;
  logic [BLINK_W-1:0]   blink_cnt, blink_cnt_d;
  logic                 blink_on, blink_on_d;
  logic [1:0]           tens;
  logic [3:0]           units;
  logic [6:0]           tens_seg, units_seg;
  logic                 expiry, reload;
  logic [7:0]           hex0_d, hex1_d;
  logic                 buzzer_d, expired_d;
  logic [7:0]           hex0_p1, hex1_p1;
  logic                 buzzer_p1, expired_p1;

  assign tens   = tens_of(count_in);
  assign units  = units_of(count_in);
  assign expiry = (prev_q != 5'd0) && (count_in == 5'd0);
  assign reload = (count_in != 5'd0);

  seg7_decoder u_tens  (.digit({2'b00, tens}), .seg(tens_seg));
  seg7_decoder u_units (.digit(units),         .seg(units_seg));

  always_comb begin
    state_d     = state;
    timer_d     = timer;
    blink_cnt_d = blink_cnt;
    blink_on_d  = blink_on;
    case (state)
      IDLE: begin
        if (expiry) begin
          state_d = BUZZ;
          timer_d = '0;
        end
      end
      BUZZ: begin
        // A reload beats buzzer completion in the same cycle.
        if (reload) begin
          state_d = IDLE;
        end else if (timer == BUZZ_LAST) begin
          state_d     = EXPIRED;
          blink_cnt_d = '0;
          blink_on_d  = 1'b1;
        end else begin
          timer_d = timer + BUZZ_W'(1);
        end
      end
      EXPIRED: begin
        if (reload) begin
          state_d = IDLE;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_cnt_d = '0;
          blink_on_d  = ~blink_on;
        end else begin
          blink_cnt_d = blink_cnt + BLINK_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they are registered yet
  // reflect the count sampled on the same edge.
  always_comb begin
    hex0_d    = SEG_BLANK;
    hex1_d    = SEG_BLANK;
    buzzer_d  = (state_d == BUZZ);
    expired_d = (state_d != IDLE);
    case (state_d)
      IDLE: begin
        hex1_d = (tens == 2'd0) ? SEG_BLANK : {1'b1, tens_seg};
        hex0_d = {~pause, units_seg};
      end
      BUZZ: begin
        hex1_d = SEG_0;
        hex0_d = SEG_0;
      end
      EXPIRED: begin
        if (blink_on_d) begin
          hex1_d = SEG_0;
          hex0_d = SEG_0;
        end
      end
      default: ;
    endcase
  end

  // Stage p1: registered state, timers and display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev_q     <= 5'd0;
      timer      <= '0;
      blink_cnt  <= '0;
      blink_on   <= 1'b0;
      hex0_p1    <= SEG_BLANK;
      hex1_p1    <= SEG_BLANK;
      buzzer_p1  <= 1'b0;
      expired_p1 <= 1'b0;
    end else begin
      state      <= state_d;
      prev_q     <= count_in;
      timer      <= timer_d;
      blink_cnt  <= blink_cnt_d;
      blink_on   <= blink_on_d;
      hex0_p1    <= hex0_d;
      hex1_p1    <= hex1_d;
      buzzer_p1  <= buzzer_d;
      expired_p1 <= expired_d;
    end
  end

  assign hex0    = hex0_p1;
  assign hex1    = hex1_p1;
  assign buzzer  = buzzer_p1;
  assign expired = expired_p1;

endmodule

// File: tb/tb_shot_clock_display.sv
// Directed bench for shot_clock_display with BUZZ_CYCLES=4, BLINK_HALF=3.
module tb_shot_clock_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] count_in;
  logic       pause;
  logic [7:0] hex0, hex1;
  logic       buzzer, expired;

  int checks   = 0;
  int failures = 0;

  shot_clock_display #(.BUZZ_CYCLES(4), .BLINK_HALF(3)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .pause(pause),
    .hex0(hex0), .hex1(hex1), .buzzer(buzzer), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; inputs set before the call are sampled at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] h1, input logic [7:0] h0,
                           input logic bz, input logic ex);
    check({tag, ".hex1"},    hex1,           h1);
    check({tag, ".hex0"},    hex0,           h0);
    check({tag, ".buzzer"},  {7'd0, buzzer}, {7'd0, bz});
    check({tag, ".expired"}, {7'd0, expired}, {7'd0, ex});
  endtask

  initial begin
    rst = 1'b1; count_in = 5'd24; pause = 1'b0;
    tick(); tick();
    check_out("reset", 8'hFF, 8'hFF, 1'b0, 1'b0);

    rst = 1'b0;
    tick();
    check_out("show24", 8'hA4, 8'h99, 1'b0, 1'b0);

    count_in = 5'd10; tick();
    check_out("show10", 8'hF9, 8'hC0, 1'b0, 1'b0);
    count_in = 5'd9;  tick();
    check_out("show9_blank", 8'hFF, 8'h90, 1'b0, 1'b0);
    count_in = 5'd31; tick();
    check_out("show31", 8'hB0, 8'hF9, 1'b0, 1'b0);

    pause = 1'b1; count_in = 5'd7; tick();
    check_out("pause7", 8'hFF, 8'h78, 1'b0, 1'b0);
    pause = 1'b0;

    // Expiry with pause held: buzzer and blink must run regardless.
    count_in = 5'd1; tick();
    check_out("show1", 8'hFF, 8'hF9, 1'b0, 1'b0);
    pause = 1'b1; count_in = 5'd0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out($sformatf("buzz%0d", i), 8'hC0, 8'hC0, 1'b1, 1'b1);
    end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] e;
      tick();
      e = (((i / 3) % 2) == 0) ? 8'hC0 : 8'hFF;
      check_out($sformatf("blink%0d", i), e, e, 1'b0, 1'b1);
    end
    pause = 1'b0;

    count_in = 5'd24; tick();
    check_out("reload_exp", 8'hA4, 8'h99, 1'b0, 1'b0);

    // Reload during the second buzzer cycle.
    count_in = 5'd1; tick();
    count_in = 5'd0; tick();
    check_out("rb_buzz1", 8'hC0, 8'hC0, 1'b1, 1'b1);
    tick();
    check_out("rb_buzz2", 8'hC0, 8'hC0, 1'b1, 1'b1);
    count_in = 5'd24; tick();
    check_out("rb_reload", 8'hA4, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out($sformatf("rb_idle%0d", i), 8'hA4, 8'h99, 1'b0, 1'b0);
    end

    // Zero straight out of reset must not sound the buzzer.
    rst = 1'b1; count_in = 5'd0; tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("zero_rst%0d", i), 8'hFF, 8'hC0, 1'b0, 1'b0);
    end

    // Reset in the middle of a buzz.
    count_in = 5'd3; tick();
    count_in = 5'd0; tick();
    check_out("mid_buzz", 8'hC0, 8'hC0, 1'b1, 1'b1);
    tick();
    rst = 1'b1; tick();
    check_out("mid_rst", 8'hFF, 8'hFF, 1'b0, 1'b0);
    rst = 1'b0; tick();
    check_out("after_rst", 8'hFF, 8'hC0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
